// File: rtl/mmio_console.sv
// Multi-channel MMIO console: per-channel byte TX/RX FIFOs, exit latch
// and PC-stall watchdog, decoded in a 256-byte window on the data port.
module mmio_console #(
  parameter logic [31:0] BASE = 32'hFFFF_FF00,
  parameter int NCH = 2,
  parameter int TXDEPTH = 16,
  parameter int RXDEPTH = 16,
  parameter int WDT_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             wready,
  input  logic [31:0]      waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             rready,
  input  logic [31:0]      raddr,
  output logic             rresp,
  output logic [31:0]      rdata,
  output logic             sel_w,
  output logic             sel_r,
  output logic [NCH-1:0]   tx_valid,
  output logic [8*NCH-1:0] tx_data,
  input  logic [NCH-1:0]   tx_ready,
  input  logic [NCH-1:0]   rx_valid,
  input  logic [8*NCH-1:0] rx_data,
  output logic [NCH-1:0]   rx_ready,
  input  logic [31:0]      pc,
  output logic             exit_valid,
  output logic [31:0]      exit_code,
  output logic             timeout
);

  localparam int TXA = $clog2(TXDEPTH);
  localparam int RXA = $clog2(RXDEPTH);

  logic wr, rd;
  logic [7:0] woff, roff;
  logic [NCH-1:0][31:0] stat;
  logic [NCH-1:0][7:0] rx_head;
  logic [NCH-1:0] rx_ne;
  logic [31:0] rd_val;
  logic [WDT_W-1:0] wdt_limit, wdt_cnt;
  logic [31:0] pc_q;
  logic unused_ok;

  assign sel_w = waddr[31:8] == BASE[31:8];
  assign sel_r = raddr[31:8] == BASE[31:8];
  assign wr = wready && sel_w;
  assign rd = rready && sel_r;
  assign woff = waddr[7:0];
  assign roff = raddr[7:0];
  assign unused_ok = ^wstrb[3:1];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [7:0] tx_mem [TXDEPTH];
    logic [7:0] rx_mem [RXDEPTH];
    logic [TXA-1:0] tx_wp, tx_rp;
    logic [RXA-1:0] rx_wp, rx_rp;
    logic [TXA:0] tx_cnt;
    logic [RXA:0] rx_cnt;
    logic tx_ovf, rx_ovf;
    logic w_hit, tx_req, st_wr;
    logic tx_full, tx_pop, tx_push;
    logic rx_full, rx_pop, rx_push;

    assign w_hit = wr && woff[7:4] == 4'(c);
    assign tx_req = w_hit && woff[3:0] == 4'h0 && wstrb[0];
    assign st_wr = w_hit && woff[3:0] == 4'h8;
    assign tx_full = tx_cnt == (TXA+1)'(TXDEPTH);
    assign tx_pop = tx_cnt != '0 && tx_ready[c];
    // a full FIFO still takes the byte if the head leaves this cycle
    assign tx_push = tx_req && (!tx_full || tx_pop);
    assign rx_full = rx_cnt == (RXA+1)'(RXDEPTH);
    assign rx_push = rx_valid[c] && !rx_full;
    assign rx_pop = rd && roff[7:4] == 4'(c)
                 && roff[3:0] == 4'h4 && rx_cnt != '0;

    always_ff @(posedge clk) begin
      if (resetb) begin
        tx_wp <= '0;
        tx_rp <= '0;
        tx_cnt <= '0;
        tx_ovf <= 1'b0;
        rx_wp <= '0;
        rx_rp <= '0;
        rx_cnt <= '0;
        rx_ovf <= 1'b0;
      end else begin
        if (tx_push) tx_wp <= tx_wp + TXA'(1);
        if (tx_pop) tx_rp <= tx_rp + TXA'(1);
        if (tx_push && !tx_pop) tx_cnt <= tx_cnt + (TXA+1)'(1);
        else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - (TXA+1)'(1);
        if (tx_req && !tx_push) tx_ovf <= 1'b1;
        else if (st_wr && wdata[4]) tx_ovf <= 1'b0;
        if (rx_push) rx_wp <= rx_wp + RXA'(1);
        if (rx_pop) rx_rp <= rx_rp + RXA'(1);
        if (rx_push && !rx_pop) rx_cnt <= rx_cnt + (RXA+1)'(1);
        else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - (RXA+1)'(1);
        if (rx_valid[c] && rx_full) rx_ovf <= 1'b1;
        else if (st_wr && wdata[5]) rx_ovf <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp] <= wdata[7:0];
      if (rx_push) rx_mem[rx_wp] <= rx_data[8*c+:8];
    end

    assign tx_valid[c] = tx_cnt != '0;
    assign tx_data[8*c+:8] = tx_mem[tx_rp];
    assign rx_ready[c] = !rx_full;
    assign rx_head[c] = rx_mem[rx_rp];
    assign rx_ne[c] = rx_cnt != '0;
    assign stat[c] = {8'h0, 8'(rx_cnt), 8'(tx_cnt), 2'b0,
                      rx_ovf, tx_ovf, rx_full,
                      rx_cnt == '0, tx_cnt == '0, tx_full};
  end

  always_comb begin
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (roff[7:4] == 4'(c)) begin
        case (roff[3:0])
          4'h4: rd_val = rx_ne[c] ? {24'h0, rx_head[c]} : '1;
          4'h8: rd_val = stat[c];
          default: ;
        endcase
      end
    end
    case (roff)
      8'hF4: rd_val = 32'(wdt_limit);
      8'hF8: rd_val = 32'(wdt_cnt);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetb) begin
      rresp <= 1'b0;
      rdata <= '0;
      exit_valid <= 1'b0;
      exit_code <= '0;
      wdt_limit <= '0;
      wdt_cnt <= '0;
      pc_q <= '0;
      timeout <= 1'b0;
    end else begin
      rresp <= rd;
      if (rd) rdata <= rd_val;
      if (wr && woff == 8'hF0) begin
        exit_valid <= 1'b1;
        exit_code <= wdata;
      end
      pc_q <= pc;
      if (wr && woff == 8'hF4) begin
        wdt_limit <= wdata[WDT_W-1:0];
        wdt_cnt <= '0;
      end else if (wdt_limit != '0 && pc == pc_q) begin
        if (wdt_cnt != '1) wdt_cnt <= wdt_cnt + WDT_W'(1);
        if (wdt_cnt + WDT_W'(1) == wdt_limit) timeout <= 1'b1;
      end else begin
        wdt_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: FIFOs, status, overflow,
// EOF reads, watchdog, exit latch and reset.
module tb_mmio_console;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic resetb = 1'b1;
  logic wready = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic rready = 1'b0;
  logic [31:0] raddr = '0;
  logic rresp;
  logic [31:0] rdata;
  logic sel_w, sel_r;
  logic [NCH-1:0] tx_valid;
  logic [8*NCH-1:0] tx_data;
  logic [NCH-1:0] tx_ready = '0;
  logic [NCH-1:0] rx_valid = '0;
  logic [8*NCH-1:0] rx_data = '0;
  logic [NCH-1:0] rx_ready;
  logic [31:0] pc = 32'h100;
  logic exit_valid;
  logic [31:0] exit_code;
  logic timeout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] v;

  always #5 clk = ~clk;

  mmio_console #(.BASE(BASE), .NCH(NCH)) dut (
    .clk(clk), .resetb(resetb),
    .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .rready(rready), .raddr(raddr), .rresp(rresp), .rdata(rdata),
    .sel_w(sel_w), .sel_r(sel_r),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pc(pc), .exit_valid(exit_valid), .exit_code(exit_code),
    .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    @(negedge clk);
    wready = 1'b1;
    waddr = {BASE[31:8], off};
    wdata = d;
    wstrb = 4'hF;
    @(negedge clk);
    wready = 1'b0;
    waddr = '0;
    wstrb = '0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    @(negedge clk);
    rready = 1'b1;
    raddr = {BASE[31:8], off};
    @(negedge clk);
    rready = 1'b0;
    raddr = '0;
    check("rresp", 32'(rresp), 32'd1);
    d = rdata;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    resetb = 1'b0;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h3);
    check("rst_exit_valid", 32'(exit_valid), 32'h0);
    check("rst_exit_code", exit_code, 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("rst_rresp", 32'(rresp), 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // decode outside the window
    raddr = 32'h0000_1008;
    waddr = 32'hFFFF_FE00;
    #1;
    check("sel_r_out", 32'(sel_r), 32'h0);
    check("sel_w_out", 32'(sel_w), 32'h0);
    @(negedge clk);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    raddr = '0;
    check("rresp_out", 32'(rresp), 32'h0);

    // ch0 TX push and drain
    wr(8'h00, 32'h41);
    wr(8'h00, 32'h42);
    check("tx0_valid", 32'(tx_valid[0]), 32'h1);
    check("tx0_head", 32'(tx_data[7:0]), 32'h41);
    rd(8'h08, v);
    check("tx0_stat2", v, 32'h0000_0204);
    tx_ready[0] = 1'b1;
    #1;
    check("tx0_drain0", 32'(tx_data[7:0]), 32'h41);
    @(negedge clk);
    check("tx0_drain1", 32'(tx_data[7:0]), 32'h42);
    @(negedge clk);
    tx_ready[0] = 1'b0;
    check("tx0_empty", 32'(tx_valid[0]), 32'h0);
    rd(8'h08, v);
    check("tx0_stat0", v, 32'h0000_0006);
    @(negedge clk);
    wready = 1'b1;
    waddr = BASE;
    wdata = 32'h55;
    wstrb = 4'hE;
    @(negedge clk);
    wready = 1'b0;
    wstrb = '0;
    check("tx0_nostrb", 32'(tx_valid[0]), 32'h0);

    // unmapped reads/writes
    wr(8'h20, 32'h77);
    rd(8'h20, v);
    check("unmap_ch2", v, 32'h0);
    rd(8'h00, v);
    check("txdata_rd", v, 32'h0);

    // ch1 fill, overflow, clear, push while full and popping
    for (int i = 0; i < 16; i++) wr(8'h10, 32'h20 + i);
    wr(8'h10, 32'h99);
    check("tx1_head", 32'(tx_data[15:8]), 32'h20);
    rd(8'h18, v);
    check("tx1_ovf", v, 32'h0000_1015);
    wr(8'h18, 32'h10);
    rd(8'h18, v);
    check("tx1_clr", v, 32'h0000_1005);
    @(negedge clk);
    tx_ready[1] = 1'b1;
    wready = 1'b1;
    waddr = {BASE[31:8], 8'h10};
    wdata = 32'h77;
    wstrb = 4'hF;
    @(negedge clk);
    wready = 1'b0;
    tx_ready[1] = 1'b0;
    check("tx1_head2", 32'(tx_data[15:8]), 32'h21);
    rd(8'h18, v);
    check("tx1_pushpop", v, 32'h0000_1005);

    // RX EOF and single byte
    rd(8'h04, v);
    check("rx0_eof", v, 32'hFFFF_FFFF);
    @(negedge clk);
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h5A;
    @(negedge clk);
    rx_valid[0] = 1'b0;
    rd(8'h04, v);
    check("rx0_byte", v, 32'h0000_005A);
    rd(8'h08, v);
    check("rx0_cnt0", v, 32'h0000_0006);

    // EOF read racing a push: byte appears on next access
    @(negedge clk);
    rready = 1'b1;
    raddr = {BASE[31:8], 8'h04};
    rx_valid[0] = 1'b1;
    rx_data[7:0] = 8'h5B;
    @(negedge clk);
    rready = 1'b0;
    rx_valid[0] = 1'b0;
    check("rx0_race_eof", rdata, 32'hFFFF_FFFF);
    rd(8'h04, v);
    check("rx0_race_byte", v, 32'h0000_005B);

    // RX overflow with 17 offered bytes
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) check("rx0_ready15", 32'(rx_ready[0]), 32'h1);
      if (i == 16) check("rx0_ready16", 32'(rx_ready[0]), 32'h0);
      rx_valid[0] = 1'b1;
      rx_data[7:0] = 8'(8'h60 + i);
    end
    @(negedge clk);
    rx_valid[0] = 1'b0;
    rd(8'h08, v);
    check("rx0_full", v, 32'h0010_002A);
    for (int i = 0; i < 16; i++) begin
      rd(8'h04, v);
      check("rx0_order", v, 32'h60 + i);
    end
    rd(8'h04, v);
    check("rx0_eof2", v, 32'hFFFF_FFFF);
    check("rx0_ready", 32'(rx_ready[0]), 32'h1);
    rd(8'h08, v);
    check("rx0_ovf_left", v, 32'h0000_0026);
    wr(8'h08, 32'h20);
    rd(8'h08, v);
    check("rx0_ovf_clr", v, 32'h0000_0006);

    // watchdog at limit 5 with pc held
    wr(8'hF4, 32'd5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("wdt_early", 32'(timeout), 32'h0);
    end
    @(negedge clk);
    check("wdt_fire", 32'(timeout), 32'h1);
    rd(8'hF4, v);
    check("wdt_limit", v, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = pc + 32'd4;
    end
    check("wdt_sticky", 32'(timeout), 32'h1);
    wr(8'hF4, 32'd0);
    rd(8'hF8, v);
    check("wdt_off_cnt", v, 32'h0);

    // exit latch, then reset with a strobe in the reset cycle
    wr(8'hF0, 32'h1);
    check("exit_valid", 32'(exit_valid), 32'h1);
    check("exit_code", exit_code, 32'h1);
    wr(8'hF0, 32'hDEAD);
    check("exit_code2", exit_code, 32'hDEAD);
    check("exit_valid2", 32'(exit_valid), 32'h1);
    wr(8'h00, 32'h33);
    check("tx_pre_rst", 32'(tx_valid[0]), 32'h1);
    @(negedge clk);
    resetb = 1'b1;
    wready = 1'b1;
    waddr = BASE;
    wdata = 32'h44;
    wstrb = 4'hF;
    @(negedge clk);
    resetb = 1'b0;
    wready = 1'b0;
    wstrb = '0;
    check("rst2_exit_valid", 32'(exit_valid), 32'h0);
    check("rst2_exit_code", exit_code, 32'h0);
    check("rst2_tx_valid", 32'(tx_valid), 32'h0);
    check("rst2_rx_ready", 32'(rx_ready), 32'h3);
    check("rst2_timeout", 32'(timeout), 32'h0);

    // limit 0 keeps the watchdog quiet
    repeat (20) @(negedge clk);
    check("wdt_dis", 32'(timeout), 32'h0);
    rd(8'hF8, v);
    check("wdt_dis_cnt", v, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
